dmem_responder: RTL and testbench

//   Multi-cycle data-memory responder: the memory-side end of the MEM-stage load/store interface.

---
 rtl/dmem_responder.sv | 89 ++++++++
 tb/tb_dmem_responder.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the MEM stage: accepts one load/store,
// stalls the pipeline for LATENCY+1 cycles, then strobes ack with the load data.
module dmem_responder #(
  parameter int DEPTH_LOG2 = 8,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        stall,
  output logic        ack,
  output logic        misalign
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                  state;
  logic [3:0]              cnt;
  logic [DEPTH_LOG2-1:0]   idx;
  logic [31:0]             wdata;
  logic                    op_write;
  logic                    mis_pending;
  logic                    req;
  logic                    commit;
  logic                    unused_addr;
  logic [31:0]             mem [0:(1<<DEPTH_LOG2)-1];

  assign req         = memread | memwrite;
  assign stall       = (state == IDLE) ? req : (state == BUSY);
  assign commit      = (state == BUSY) && (cnt == '0);
  // Upper address bits are deliberately dropped so the index wraps.
  assign unused_addr = ^{address[31:DEPTH_LOG2+2]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      idx         <= '0;
      wdata       <= '0;
      op_write    <= 1'b0;
      mis_pending <= 1'b0;
      read_data   <= '0;
      ack         <= 1'b0;
      misalign    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ack      <= 1'b0;
          misalign <= 1'b0;
          if (req) begin
            idx         <= address[DEPTH_LOG2+1:2];
            wdata       <= write_data;
            op_write    <= memwrite;
            mis_pending <= |address[1:0];
            cnt         <= 4'(LATENCY - 1);
            state       <= BUSY;
          end
        end
        BUSY: begin
          if (cnt == '0) begin
            state    <= DONE;
            ack      <= 1'b1;
            misalign <= mis_pending;
            if (mis_pending)    read_data <= '0;
            else if (!op_write) read_data <= mem[idx];
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          ack      <= 1'b0;
          misalign <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Array has no reset; an aborted access never reaches commit since reset forces IDLE.
  always_ff @(posedge clk) begin
    if (commit && op_write && !mis_pending) mem[idx] <= wdata;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus randomized
// accesses checked against an associative-array memory model.
module tb_dmem_responder;
  localparam int DL2 = 8;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        memread, memwrite;
  logic [31:0] address, write_data;
  logic [31:0] read_data;
  logic        stall, ack, misalign;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] model [int];

  dmem_responder #(.DEPTH_LOG2(DL2), .LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .memread(memread), .memwrite(memwrite),
    .address(address), .write_data(write_data), .read_data(read_data),
    .stall(stall), .ack(ack), .misalign(misalign)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, required finish");
    $fatal(1, "watchdog");
  end

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % (1 << DL2));
  endfunction

  // Issues one request starting at a negedge; returns at the ack negedge (hold=1)
  // or one cycle later with the following-cycle stall/ack observed (hold=0).
  task automatic access(input bit rd, input bit wr, input logic [31:0] a,
                        input logic [31:0] d, input bit hold,
                        output logic [31:0] rdat, output bit mis,
                        output int stall_cycles, output bit got_ack,
                        output bit post_stall, output bit post_ack);
    memread = rd; memwrite = wr; address = a; write_data = d;
    stall_cycles = 0; got_ack = 0; rdat = 'x; mis = 0;
    post_stall = 0; post_ack = 0;
    #1;
    if (stall) stall_cycles++;
    for (int i = 0; i < 40 && !got_ack; i++) begin
      @(negedge clk);
      if (ack) begin
        got_ack = 1; rdat = read_data; mis = misalign;
        if (stall) stall_cycles += 100;
      end else if (stall) stall_cycles++;
    end
    if (!hold) begin
      memread = 0; memwrite = 0;
      @(negedge clk);
      post_stall = stall; post_ack = ack;
    end
  endtask

  task automatic test_reset;
    rst_n = 0; memread = 0; memwrite = 0; address = '0; write_data = '0;
    #2;
    n_cmp++;
    if ({stall, ack, misalign, read_data} !== 35'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got stall=%b ack=%b mis=%b rd=%h, required all 0",
               stall, ack, misalign, read_data);
    end
    @(negedge clk); rst_n = 1;
    @(negedge clk);
    n_cmp++;
    if (stall !== 1'b0 || ack !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_no_req: got stall=%b ack=%b, required 0 0", stall, ack);
    end
  endtask

  task automatic test_basic;
    logic [31:0] r; bit m, ga, ps, pa; int sc;
    access(0, 1, 32'h10, 32'hDEADBEEF, 0, r, m, sc, ga, ps, pa);
    model[widx(32'h10)] = 32'hDEADBEEF;
    n_cmp++;
    if (!ga || sc != LAT + 1 || m) begin
      n_bad++;
      $display("FAIL write_timing: got ack=%b stall_cycles=%0d mis=%b, required 1 %0d 0",
               ga, sc, m, LAT + 1);
    end
    n_cmp++;
    if (ps || pa) begin
      n_bad++;
      $display("FAIL write_post_idle: got stall=%b ack=%b, required 0 0", ps, pa);
    end
    access(1, 0, 32'h10, 32'h0, 0, r, m, sc, ga, ps, pa);
    n_cmp++;
    if (!ga || sc != LAT + 1 || r !== 32'hDEADBEEF) begin
      n_bad++;
      $display("FAIL read_basic: got ack=%b stall_cycles=%0d rd=%h, required 1 %0d deadbeef",
               ga, sc, r, LAT + 1);
    end
  endtask

  task automatic test_both_ops;
    logic [31:0] r; bit m, ga, ps, pa; int sc;
    access(1, 1, 32'h20, 32'h1234, 0, r, m, sc, ga, ps, pa);
    model[widx(32'h20)] = 32'h1234;
    access(1, 0, 32'h20, 32'h0, 0, r, m, sc, ga, ps, pa);
    n_cmp++;
    if (!ga || r !== 32'h0000_1234) begin
      n_bad++;
      $display("FAIL write_wins: got ack=%b rd=%h, required 1 00001234", ga, r);
    end
  endtask

  task automatic test_misalign;
    logic [31:0] r; bit m, ga, ps, pa; int sc;
    access(1, 0, 32'h13, 32'h0, 0, r, m, sc, ga, ps, pa);
    n_cmp++;
    if (!ga || !m || r !== 32'h0 || sc != LAT + 1) begin
      n_bad++;
      $display("FAIL misalign_read: got ack=%b mis=%b rd=%h sc=%0d, required 1 1 0 %0d",
               ga, m, r, sc, LAT + 1);
    end
    access(0, 1, 32'h12, 32'hFFFF_FFFF, 0, r, m, sc, ga, ps, pa);
    access(1, 0, 32'h10, 32'h0, 0, r, m, sc, ga, ps, pa);
    n_cmp++;
    if (m || r !== model[widx(32'h10)]) begin
      n_bad++;
      $display("FAIL misalign_nowrite: got mis=%b rd=%h, required 0 %h", m, r, model[widx(32'h10)]);
    end
  endtask

  task automatic test_abort;
    logic [31:0] r; bit m, ga, ps, pa; int sc;
    access(0, 1, 32'h40, 32'h0BAD_F00D, 0, r, m, sc, ga, ps, pa);
    model[widx(32'h40)] = 32'h0BAD_F00D;
    memwrite = 1; memread = 0; address = 32'h40; write_data = 32'hA5A5A5A5;
    @(negedge clk);
    memwrite = 0;
    #2 rst_n = 0;
    #1;
    n_cmp++;
    if (stall !== 1'b0 || ack !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_busy: got stall=%b ack=%b, required 0 0", stall, ack);
    end
    @(negedge clk); rst_n = 1;
    @(negedge clk);
    access(1, 0, 32'h40, 32'h0, 1, r, m, sc, ga, ps, pa);
    memread = 0;
    n_cmp++;
    if (!ga || r !== 32'h0BAD_F00D) begin
      n_bad++;
      $display("FAIL abort_no_commit: got ack=%b rd=%h, required 1 0badf00d", ga, r);
    end
    #2 rst_n = 0;
    #1;
    n_cmp++;
    if (read_data !== 32'h0 || ack !== 1'b0 || stall !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_done: got rd=%h ack=%b stall=%b, required 0 0 0", read_data, ack, stall);
    end
    @(negedge clk); rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_wrap_back_to_back;
    logic [31:0] r; bit m, ga, ps, pa; int sc, n;
    access(0, 1, 32'h400, 32'h77, 0, r, m, sc, ga, ps, pa);
    model[widx(32'h400)] = 32'h77;
    access(1, 0, 32'h000, 32'h0, 1, r, m, sc, ga, ps, pa);
    n_cmp++;
    if (!ga || r !== 32'h77) begin
      n_bad++;
      $display("FAIL wrap_read: got ack=%b rd=%h, required 1 00000077", ga, r);
    end
    address = 32'h10;
    #1;
    n_cmp++;
    if (stall !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_done_stall: got %b, required 0", stall);
    end
    @(negedge clk);
    n_cmp++;
    if (stall !== 1'b1 || ack !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_idle_gap: got stall=%b ack=%b, required 1 0", stall, ack);
    end
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n++;
      if (ack) break;
    end
    memread = 0;
    n_cmp++;
    if (ack !== 1'b1 || n != LAT + 1 || read_data !== model[widx(32'h10)]) begin
      n_bad++;
      $display("FAIL b2b_second: got ack=%b cycles=%0d rd=%h, required 1 %0d %h",
               ack, n, read_data, LAT + 1, model[widx(32'h10)]);
    end
    @(negedge clk);
  endtask

  task automatic test_random;
    logic [31:0] r, a, d; bit m, ga, ps, pa, rd, wr, mis_exp; int sc, op, k;
    for (int i = 0; i < 60; i++) begin
      op = int'($urandom_range(0, 3));
      rd = (op == 0 || op == 2 || op == 3);
      wr = (op == 1 || op == 2);
      a  = ($urandom & 32'hFFFF_FC00) | ($urandom_range(0, 15) << 2);
      if ($urandom_range(0, 4) == 0) a[1:0] = 2'($urandom_range(1, 3));
      d  = $urandom;
      mis_exp = (a[1:0] != 2'b00);
      k = widx(a);
      access(rd, wr, a, d, 0, r, m, sc, ga, ps, pa);
      n_cmp++;
      if (!ga || sc != LAT + 1 || m != mis_exp || ps || pa) begin
        n_bad++;
        $display("FAIL rand_handshake[%0d]: got ack=%b sc=%0d mis=%b post=%b%b, required 1 %0d %b 00",
                 i, ga, sc, m, ps, pa, LAT + 1, mis_exp);
      end
      if (mis_exp && !wr) begin
        n_cmp++;
        if (r !== 32'h0) begin
          n_bad++;
          $display("FAIL rand_misread[%0d]: got %h, required 0", i, r);
        end
      end else if (!wr && model.exists(k)) begin
        n_cmp++;
        if (r !== model[k]) begin
          n_bad++;
          $display("FAIL rand_read[%0d] addr=%h: got %h, required %h", i, a, r, model[k]);
        end
      end
      if (wr && !mis_exp) model[k] = d;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_both_ops();
    test_misalign();
    test_abort();
    test_wrap_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
